// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, reset PC and fetch-entry payload for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    localparam logic [AW-1:0] RESET_PC_DEF = 32'h0000_3000;

    // One fetched instruction together with the PC it was read from.
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] ir;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [AW-1:0] word_align(input logic [AW-1:0] addr);
        return addr & {{(AW-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and the decode link.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic          im_req;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_ir;
    logic [AW-1:0] id_pc_plus4;

    // Fetch unit side.
    modport master (
        output im_req, im_addr, id_valid, id_pc, id_ir, id_pc_plus4,
        input  im_rdata, redirect_valid, redirect_pc, id_ready
    );

    // Memory / decode / redirect side.
    modport slave (
        input  im_req, im_addr, id_valid, id_pc, id_ir, id_pc_plus4,
        output im_rdata, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/if_fetch_unit_buf.sv
// Two-entry fetch FIFO with flush; head entry and its PC+4 are held in registers.
module if_fetch_unit_buf
    import if_fetch_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [1:0]    occ,
    output fetch_entry_t  head,
    output logic [AW-1:0] head_pc_plus4
);

    fetch_entry_t  ent0_q, ent0_d;
    fetch_entry_t  ent1_q, ent1_d;
    logic [1:0]    occ_q, occ_d;
    logic [AW-1:0] plus4_q, plus4_d;

    // Next-state of the two slots; slot 0 is always the head.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        if (flush) begin
            occ_d = 2'd0;
        end else if (push && pop) begin
            if (occ_q == 2'd1) begin
                ent0_d = push_data;
            end else begin
                ent0_d = ent1_q;
                ent1_d = push_data;
            end
        end else if (push) begin
            if (occ_q == 2'd0) begin
                ent0_d = push_data;
                occ_d  = 2'd1;
            end else begin
                ent1_d = push_data;
                occ_d  = 2'd2;
            end
        end else if (pop) begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
        end
        plus4_d = ent0_d.pc + AW'(4);
    end

    // Slot and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            occ_q   <= 2'd0;
            plus4_q <= '0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            occ_q   <= occ_d;
            plus4_q <= plus4_d;
        end
    end

    assign occ           = occ_q;
    assign head          = ent0_q;
    assign head_pc_plus4 = plus4_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and feeds decode.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [AW-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_unit_if.master   bus
);

    logic [AW-1:0] pc_q;
    logic          inflight_q;
    logic [AW-1:0] inflight_pc_q;

    logic          pop;
    logic          push;
    logic          issue;
    logic [1:0]    occ;
    logic [2:0]    used;
    fetch_entry_t  push_data;
    fetch_entry_t  head;
    logic [AW-1:0] head_pc_plus4;

    // Slots committed after this cycle's pop; a new read needs one free slot.
    always_comb begin
        pop   = bus.id_valid & bus.id_ready;
        used  = 3'(occ) + 3'(inflight_q) - 3'(pop);
        issue = rst & !bus.redirect_valid & (used < 3'd2);
    end

    // A redirect cycle never issues, so dropping the push in that cycle is
    // enough to kill the only response that can be in flight.
    always_comb begin
        push         = inflight_q & !bus.redirect_valid;
        push_data.pc = inflight_pc_q;
        push_data.ir = bus.im_rdata;
    end

    // PC and in-flight tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= word_align(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
            if (bus.redirect_valid) begin
                pc_q <= word_align(bus.redirect_pc);
            end else if (issue) begin
                pc_q <= pc_q + AW'(4);
            end
        end
    end

    if_fetch_unit_buf u_buf (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .push_data     (push_data),
        .pop           (pop),
        .flush         (bus.redirect_valid),
        .occ           (occ),
        .head          (head),
        .head_pc_plus4 (head_pc_plus4)
    );

    assign bus.im_req      = issue;
    assign bus.im_addr     = pc_q;
    assign bus.id_valid    = (occ != 2'd0);
    assign bus.id_pc       = head.pc;
    assign bus.id_ir       = head.ir;
    assign bus.id_pc_plus4 = head_pc_plus4;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model, in-order scoreboard and directed checks.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    if_fetch_unit_if bus ();

    if_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Instruction image: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    // Expected fetch stream from a start address.
    task automatic sb_restart(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // One-cycle synchronous instruction memory.
    always @(posedge clk) begin
        if (bus.im_req) bus.im_rdata <= mem_word(bus.im_addr);
    end

    // Scoreboard: every accepted head must be the next expected PC.
    always @(negedge clk) begin : sb_mon
        logic [31:0] e;
        if (!rst) begin
            sb_restart(32'h0000_3000);
        end else begin
            if (bus.id_valid && bus.id_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_pc", bus.id_pc, e);
                    check_eq("sb_ir", bus.id_ir, mem_word(e));
                    check_eq("sb_pc_plus4", bus.id_pc_plus4, e + 32'd4);
                end
            end
            if (bus.redirect_valid) sb_restart(bus.redirect_pc & 32'hFFFF_FFFC);
            if (bus.im_req) check_eq("im_addr_align", 32'(bus.im_addr[1:0]), 32'd0);
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        rst                = 1'b0;

        // Reset state
        repeat (3) next_cyc();
        at_neg();
        check_eq("rst_im_req", 32'(bus.im_req), 32'd0);
        check_eq("rst_im_addr", bus.im_addr, 32'h0000_3000);
        check_eq("rst_id_valid", 32'(bus.id_valid), 32'd0);
        check_eq("rst_id_pc", bus.id_pc, 32'd0);
        check_eq("rst_id_ir", bus.id_ir, 32'd0);
        check_eq("rst_id_pc_plus4", bus.id_pc_plus4, 32'd0);

        // Release with decode always ready: 2-cycle latency, then 1/cycle
        next_cyc(); rst = 1'b1; bus.id_ready = 1'b1;
        at_neg();
        check_eq("c0_im_req", 32'(bus.im_req), 32'd1);
        check_eq("c0_im_addr", bus.im_addr, 32'h0000_3000);
        check_eq("c0_id_valid", 32'(bus.id_valid), 32'd0);
        next_cyc(); at_neg();
        check_eq("c1_id_valid", 32'(bus.id_valid), 32'd0);
        next_cyc(); at_neg();
        check_eq("c2_id_valid", 32'(bus.id_valid), 32'd1);
        check_eq("c2_id_pc", bus.id_pc, 32'h0000_3000);
        check_eq("c2_id_pc_plus4", bus.id_pc_plus4, 32'h0000_3004);
        next_cyc(); at_neg();
        check_eq("c3_id_pc", bus.id_pc, 32'h0000_3004);
        next_cyc(); at_neg();
        check_eq("c4_id_pc", bus.id_pc, 32'h0000_3008);
        repeat (4) next_cyc();

        // Stall: two entries held, no further reads, head stable
        rst = 1'b0; bus.id_ready = 1'b0;
        next_cyc(); rst = 1'b1;
        next_cyc();
        next_cyc(); at_neg();
        check_eq("stall_first_valid", 32'(bus.id_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            at_neg();
            check_eq("stall_im_req", 32'(bus.im_req), 32'd0);
            check_eq("stall_head_pc", bus.id_pc, 32'h0000_3000);
            next_cyc();
        end
        bus.id_ready = 1'b1;
        at_neg();
        check_eq("unstall_pc0", bus.id_pc, 32'h0000_3000);
        next_cyc(); at_neg();
        check_eq("unstall_pc1", bus.id_pc, 32'h0000_3004);
        next_cyc(); at_neg();
        check_eq("unstall_pc2", bus.id_pc, 32'h0000_3008);
        repeat (4) next_cyc();

        // Redirect with 0x3004 buffered and 0x3008 in flight
        rst = 1'b0;
        next_cyc(); rst = 1'b1;
        next_cyc();
        next_cyc();
        next_cyc();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_3040; bus.id_ready = 1'b0;
        at_neg();
        check_eq("redir_head_pc", bus.id_pc, 32'h0000_3004);
        check_eq("redir_im_req", 32'(bus.im_req), 32'd0);
        next_cyc(); bus.redirect_valid = 1'b0; bus.id_ready = 1'b1;
        at_neg();
        check_eq("redir_id_valid1", 32'(bus.id_valid), 32'd0);
        check_eq("redir_im_req1", 32'(bus.im_req), 32'd1);
        check_eq("redir_im_addr", bus.im_addr, 32'h0000_3040);
        next_cyc(); at_neg();
        check_eq("redir_id_valid2", 32'(bus.id_valid), 32'd0);
        next_cyc(); at_neg();
        check_eq("redir_id_pc", bus.id_pc, 32'h0000_3040);
        repeat (3) next_cyc();

        // Misaligned redirect target
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_3043;
        next_cyc(); bus.redirect_valid = 1'b0;
        at_neg();
        check_eq("misalign_im_addr", bus.im_addr, 32'h0000_3040);
        next_cyc(); next_cyc(); at_neg();
        check_eq("misalign_id_pc", bus.id_pc, 32'h0000_3040);
        repeat (3) next_cyc();

        // PC wrap past the top of the address space
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
        next_cyc(); bus.redirect_valid = 1'b0;
        at_neg();
        check_eq("wrap_im_addr", bus.im_addr, 32'hFFFF_FFF8);
        next_cyc(); next_cyc(); at_neg();
        check_eq("wrap_pc0", bus.id_pc, 32'hFFFF_FFF8);
        next_cyc(); at_neg();
        check_eq("wrap_pc1", bus.id_pc, 32'hFFFF_FFFC);
        check_eq("wrap_plus4_1", bus.id_pc_plus4, 32'h0000_0000);
        next_cyc(); at_neg();
        check_eq("wrap_pc2", bus.id_pc, 32'h0000_0000);
        check_eq("wrap_plus4_2", bus.id_pc_plus4, 32'h0000_0004);
        repeat (3) next_cyc();

        // Reset mid-stream with the buffer full
        bus.id_ready = 1'b0;
        repeat (3) next_cyc();
        at_neg();
        check_eq("full_id_valid", 32'(bus.id_valid), 32'd1);
        check_eq("full_im_req", 32'(bus.im_req), 32'd0);
        next_cyc(); rst = 1'b0;
        next_cyc(); rst = 1'b1; bus.id_ready = 1'b1;
        at_neg();
        check_eq("midrst_id_valid", 32'(bus.id_valid), 32'd0);
        check_eq("midrst_im_req", 32'(bus.im_req), 32'd1);
        check_eq("midrst_im_addr", bus.im_addr, 32'h0000_3000);
        repeat (4) next_cyc();

        // Reset and redirect together: reset wins
        rst = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_5000;
        next_cyc(); rst = 1'b1; bus.redirect_valid = 1'b0;
        at_neg();
        check_eq("rstredir_im_addr", bus.im_addr, 32'h0000_3000);
        check_eq("rstredir_im_req", 32'(bus.im_req), 32'd1);
        next_cyc(); next_cyc(); at_neg();
        check_eq("rstredir_id_pc", bus.id_pc, 32'h0000_3000);
        repeat (3) next_cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
